// File: rtl/ad7616_spi_responder.sv
// -----------------------------------------------------------------------------
// ad7616_spi_responder
//
// Synthesizable device model of the AD7616 serial interface, used as the SPI
// responder in the AD7616 SPI engine bench. It answers CNVST with a fixed-width
// BUSY pulse and serves dual-lane conversion words on SDOA/SDOB. It also accepts
// 16-bit command frames that write a small register file or queue a register
// read-back for the next frame. Every pin is sampled in the clk domain, so clk
// must run at least 4x faster than spi_sclk.
//
// Optional feature macro: AD7616_RESP_ERR_EN
//   defined   -> err_ovr port plus its sticky protocol-error logic
//   undefined -> no err_ovr port; all other behaviour is identical
//
// Ports
//   clk       in   1   system clock
//   reset     in   1   synchronous, active-high reset
//   cnvst     in   1   conversion start (asynchronous to clk)
//   busy      out  1   conversion in progress
//   spi_sclk  in   1   serial clock from host, idles low
//   spi_cs    in   1   chip select, active low
//   spi_sdo   in   1   host MOSI (command frames)
//   spi_sdi   out  2   responder MISO, [0] = lane A, [1] = lane B
//   conv_cnt  out 12   number of completed conversions (debug)
//   err_ovr   out  1   sticky protocol error (AD7616_RESP_ERR_EN only)
// -----------------------------------------------------------------------------
module ad7616_spi_responder #(
   parameter int DATA_WIDTH  = 16,
   parameter int BUSY_CYCLES = 40,
   parameter int REG_COUNT   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cnvst,
   output logic        busy,
   input  logic        spi_sclk,
   input  logic        spi_cs,
   input  logic        spi_sdo,
   output logic [1:0]  spi_sdi,
   output logic [11:0] conv_cnt
`ifdef AD7616_RESP_ERR_EN
   ,
   output logic        err_ovr
`endif
);

   localparam int CNT_W = $clog2(BUSY_CYCLES);
   localparam int BC_W  = $clog2(DATA_WIDTH + 2);

   localparam logic [BC_W-1:0] BC_FULL = BC_W'(DATA_WIDTH);
   localparam logic [BC_W-1:0] BC_SAT  = BC_W'(DATA_WIDTH + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CONV = 1'b1;

   // Input synchronizers. Stage [2] is one clk older than [1], and the edge
   // detectors compare those two stages.
   logic [2:0] cnvst_sync_q;
   logic [2:0] sclk_sync_q;
   logic [2:0] cs_sync_q;
   logic [1:0] sdo_sync_q;

   logic cnvst_rise;
   logic sclk_rise;
   logic sclk_fall;
   logic cs_fall;
   logic cs_rise;
   logic cs_active;

   logic [0:0]            state_q,    state_d;
   logic [CNT_W-1:0]      cnt_q,      cnt_d;
   logic [11:0]           conv_cnt_q, conv_cnt_d;
   logic [DATA_WIDTH-1:0] data_a_q,   data_a_d;
   logic [DATA_WIDTH-1:0] data_b_q,   data_b_d;
   logic [DATA_WIDTH-1:0] shift_a_q,  shift_a_d;
   logic [DATA_WIDTH-1:0] shift_b_q,  shift_b_d;
   logic [DATA_WIDTH-1:0] cmd_q,      cmd_d;
   logic [BC_W-1:0]       bit_cnt_q,  bit_cnt_d;
   logic                  rd_pend_q,  rd_pend_d;
   logic [2:0]            rd_addr_q,  rd_addr_d;
   logic [DATA_WIDTH-1:0] regfile_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regfile_d [REG_COUNT];

   assign cnvst_rise =  cnvst_sync_q[1] & ~cnvst_sync_q[2];
   assign sclk_rise  =  sclk_sync_q[1]  & ~sclk_sync_q[2];
   assign sclk_fall  = ~sclk_sync_q[1]  &  sclk_sync_q[2];
   assign cs_fall    = ~cs_sync_q[1]    &  cs_sync_q[2];
   assign cs_rise    =  cs_sync_q[1]    & ~cs_sync_q[2];
   assign cs_active  = ~cs_sync_q[1];

   // NOTE: every variable gets a default at the top of always_comb, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      conv_cnt_d = conv_cnt_q;
      data_a_d   = data_a_q;
      data_b_d   = data_b_q;
      shift_a_d  = shift_a_q;
      shift_b_d  = shift_b_q;
      cmd_d      = cmd_q;
      bit_cnt_d  = bit_cnt_q;
      rd_pend_d  = rd_pend_q;
      rd_addr_d  = rd_addr_q;
      regfile_d  = regfile_q;

      // Conversion FSM. A cnvst edge seen in CONV is ignored, so a stray pulse
      // can neither restart nor stretch BUSY.
      case (state_q)
         ST_IDLE: begin
            if (cnvst_rise) begin
               state_d = ST_CONV;
               cnt_d   = CNT_W'(BUSY_CYCLES - 1);
            end
         end
         ST_CONV: begin
            if (cnt_q == '0) begin
               data_a_d   = DATA_WIDTH'({4'hA, conv_cnt_q});
               data_b_d   = DATA_WIDTH'({4'hB, conv_cnt_q});
               conv_cnt_d = conv_cnt_q + 12'd1;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Frame start loads from the registered data words. A conversion that
      // finishes in the same clk updates data_*_d only, so the frame still
      // serves the previous result.
      if (cs_fall) begin
         if (rd_pend_q) begin
            shift_a_d = regfile_q[rd_addr_q];
            shift_b_d = '0;
            rd_pend_d = 1'b0;
         end else begin
            shift_a_d = data_a_q;
            shift_b_d = data_b_q;
         end
         cmd_d     = '0;
         bit_cnt_d = '0;
      end else if (cs_active && sclk_fall) begin
         shift_a_d = {shift_a_q[DATA_WIDTH-2:0], 1'b0};
         shift_b_d = {shift_b_q[DATA_WIDTH-2:0], 1'b0};
      end

      // The command shift builds on the values just cleared by a frame start.
      // An sclk rise in the same clk as the cs fall therefore lands in the new
      // frame.
      if (cs_active && sclk_rise) begin
         cmd_d = {cmd_d[DATA_WIDTH-2:0], sdo_sync_q[1]};
         if (bit_cnt_d != BC_SAT) begin
            bit_cnt_d = bit_cnt_d + BC_W'(1);
         end
      end

      // Frame end. Only an exactly full-length frame is decoded.
      if (cs_rise) begin
         shift_a_d = '0;
         shift_b_d = '0;
         if (bit_cnt_q == BC_FULL) begin
            if (cmd_q[DATA_WIDTH-1]) begin
               regfile_d[cmd_q[11:9]] = DATA_WIDTH'(cmd_q[8:0]);
            end else if (cmd_q != '0) begin
               rd_addr_d = cmd_q[11:9];
               rd_pend_d = 1'b1;
            end
         end
      end
   end

   // NOTE: sequential state is assigned only with non-blocking (<=). Every
   // register then samples its pre-edge value, whatever the statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // The cs synchronizer resets to its idle (high) level, so a high cs
         // pin does not look like a frame edge after reset.
         cnvst_sync_q <= '0;
         sclk_sync_q  <= '0;
         cs_sync_q    <= '1;
         sdo_sync_q   <= '0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         conv_cnt_q   <= '0;
         data_a_q     <= '0;
         data_b_q     <= '0;
         shift_a_q    <= '0;
         shift_b_q    <= '0;
         cmd_q        <= '0;
         bit_cnt_q    <= '0;
         rd_pend_q    <= 1'b0;
         rd_addr_q    <= '0;
         // NOTE: the register file is small and has a defined reset value, so
         // it is cleared here. A large RAM would normally be left unreset.
         regfile_q    <= '{default: '0};
      end else begin
         cnvst_sync_q <= {cnvst_sync_q[1:0], cnvst};
         sclk_sync_q  <= {sclk_sync_q[1:0], spi_sclk};
         cs_sync_q    <= {cs_sync_q[1:0], spi_cs};
         sdo_sync_q   <= {sdo_sync_q[0], spi_sdo};
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         conv_cnt_q   <= conv_cnt_d;
         data_a_q     <= data_a_d;
         data_b_q     <= data_b_d;
         shift_a_q    <= shift_a_d;
         shift_b_q    <= shift_b_d;
         cmd_q        <= cmd_d;
         bit_cnt_q    <= bit_cnt_d;
         rd_pend_q    <= rd_pend_d;
         rd_addr_q    <= rd_addr_d;
         regfile_q    <= regfile_d;
      end
   end

   assign busy     = (state_q == ST_CONV);
   assign conv_cnt = conv_cnt_q;
   // The shift registers are zero outside a frame, so MISO idles at 0.
   assign spi_sdi  = {shift_b_q[DATA_WIDTH-1], shift_a_q[DATA_WIDTH-1]};

`ifdef AD7616_RESP_ERR_EN
   // Sticky error: a cnvst edge during BUSY, or a frame that ends partway
   // through a word. Only reset clears it.
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if ((cnvst_rise && (state_q == ST_CONV)) ||
                   (cs_rise && (bit_cnt_q != '0) && (bit_cnt_q != BC_FULL))) begin
         err_q <= 1'b1;
      end
   end

   assign err_ovr = err_q;
`endif

endmodule

// File: tb/tb_ad7616_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_ad7616_spi_responder
//
// Directed bench for ad7616_spi_responder: conversion timing, dual-lane
// readout, register write/read-back, overlong and short frames, and reset in
// the middle of a frame. Inputs are driven, and outputs sampled, on the
// falling clk edge. One SPI half-period lasts 8 clks.
// -----------------------------------------------------------------------------
module tb_ad7616_spi_responder;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cnvst;
   logic        busy;
   logic        spi_sclk;
   logic        spi_cs;
   logic        spi_sdo;
   logic [1:0]  spi_sdi;
   logic [11:0] conv_cnt;
`ifdef AD7616_RESP_ERR_EN
   logic        err_ovr;
`endif

   int tests = 0;
   int fails = 0;

   logic [31:0] lane_a;
   logic [31:0] lane_b;
   int          lat;
   int          width;
   logic        seen;

   always #5 clk = ~clk;

   ad7616_spi_responder dut (
      .clk      (clk),
      .reset    (reset),
      .cnvst    (cnvst),
      .busy     (busy),
      .spi_sclk (spi_sclk),
      .spi_cs   (spi_cs),
      .spi_sdo  (spi_sdo),
      .spi_sdi  (spi_sdi),
      .conv_cnt (conv_cnt)
`ifdef AD7616_RESP_ERR_EN
      ,
      .err_ovr  (err_ovr)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulses cnvst. Returns clks from the pulse to busy rising (-1 on timeout)
   // and the number of clks busy stays high. If glitch_at >= 0, a second cnvst
   // pulse is issued on that busy cycle.
   task automatic run_conv(input int glitch_at, output int latency, output int busy_w);
      latency = -1;
      busy_w  = 0;
      cnvst   = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 2) cnvst = 1'b0;
         if (busy) begin
            latency = i;
            break;
         end
      end
      cnvst = 1'b0;
      if (latency >= 0) begin
         busy_w = 1;
         for (int i = 0; i < 200; i++) begin
            if (busy_w == glitch_at)     cnvst = 1'b1;
            if (busy_w == glitch_at + 2) cnvst = 1'b0;
            @(negedge clk);
            if (!busy) break;
            busy_w++;
         end
      end
      cnvst = 1'b0;
   endtask

   // Runs one frame of nbits sclk cycles while sending cmd MSB first. Both
   // MISO lanes are captured just before each rising sclk edge.
   task automatic frame(input int nbits, input logic [15:0] cmd,
                        output logic [31:0] la, output logic [31:0] lb);
      la     = '0;
      lb     = '0;
      spi_cs = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         spi_sdo = (i < 16) ? cmd[15-i] : 1'b0;
         wait_clks(HALF);
         la = {la[30:0], spi_sdi[0]};
         lb = {lb[30:0], spi_sdi[1]};
         spi_sclk = 1'b1;
         wait_clks(HALF);
         spi_sclk = 1'b0;
      end
      spi_sdo = 1'b0;
      wait_clks(HALF);
      spi_cs = 1'b1;
      wait_clks(HALF);
   endtask

   initial begin
      reset    = 1'b1;
      cnvst    = 1'b0;
      spi_sclk = 1'b0;
      spi_cs   = 1'b1;
      spi_sdo  = 1'b0;
      wait_clks(5);
      reset = 1'b0;
      wait_clks(2);

      // Reset state
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_sdi", 32'(spi_sdi), 32'd0);
      check("reset_conv_cnt", 32'(conv_cnt), 32'd0);
`ifdef AD7616_RESP_ERR_EN
      check("reset_err", 32'(err_ovr), 32'd0);
`endif

      // First conversion: busy rises 3-4 clks after cnvst and lasts 40 clks
      run_conv(-10, lat, width);
      check("conv1_latency_ok", 32'((lat >= 3) && (lat <= 4)), 32'd1);
      check("conv1_width", 32'(width), 32'd40);
      check("conv1_cnt", 32'(conv_cnt), 32'd1);

      // Second conversion latches {A,001}/{B,001}
      run_conv(-10, lat, width);
      check("conv2_cnt", 32'(conv_cnt), 32'd2);
      wait_clks(4);
      frame(16, 16'h0000, lane_a, lane_b);
      check("data_lane_a", lane_a, 32'h0000_A001);
      check("data_lane_b", lane_b, 32'h0000_B001);

      // Register write, read command, then read-back frame
      frame(16, 16'h8A55, lane_a, lane_b);
      frame(16, 16'h0A00, lane_a, lane_b);
      frame(16, 16'h0000, lane_a, lane_b);
      check("regrd_lane_a", lane_a, 32'h0000_0055);
      check("regrd_lane_b", lane_b, 32'h0000_0000);
      frame(16, 16'h0000, lane_a, lane_b);
      check("after_rd_lane_a", lane_a, 32'h0000_A001);

      // cnvst pulse on busy cycle 10 is ignored: same width, one count
      run_conv(10, lat, width);
      check("glitch_width", 32'(width), 32'd40);
      check("glitch_cnt", 32'(conv_cnt), 32'd3);
      wait_clks(60);
      check("glitch_no_restart", 32'(busy), 32'd0);
      check("glitch_cnt_hold", 32'(conv_cnt), 32'd3);
`ifdef AD7616_RESP_ERR_EN
      check("glitch_err", 32'(err_ovr), 32'd1);
`endif

      // 20-sclk frame: the 4 bits past the word read as zero
      frame(20, 16'h0000, lane_a, lane_b);
      check("long_lane_a", lane_a, 32'h000A_0020);
      check("long_lane_b", lane_b, 32'h000B_0020);

      // 12-bit write frame is discarded, so register 5 still holds 0x055
      frame(12, 16'h8A77, lane_a, lane_b);
      frame(16, 16'h0A00, lane_a, lane_b);
      frame(16, 16'h0000, lane_a, lane_b);
      check("short_wr_lane_a", lane_a, 32'h0000_0055);
      check("short_wr_lane_b", lane_b, 32'h0000_0000);

      // Reset 5 sclks into a frame while a conversion is running
      spi_cs = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_clks(HALF);
         spi_sclk = 1'b1;
         wait_clks(HALF);
         spi_sclk = 1'b0;
      end
      cnvst = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 1) cnvst = 1'b0;
         if (busy) begin
            seen = 1'b1;
            break;
         end
      end
      cnvst = 1'b0;
      check("midrst_busy_seen", 32'(seen), 32'd1);
      reset  = 1'b1;
      spi_cs = 1'b1;
      wait_clks(1);
      check("midrst_sdi", 32'(spi_sdi), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_cnt", 32'(conv_cnt), 32'd0);
      wait_clks(3);
      reset = 1'b0;
      wait_clks(4);
      run_conv(-10, lat, width);
      check("post_rst_width", 32'(width), 32'd40);
      wait_clks(4);
      frame(16, 16'h0000, lane_a, lane_b);
      check("post_rst_lane_a", lane_a, 32'h0000_A000);
      check("post_rst_lane_b", lane_b, 32'h0000_B000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
